// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: registered round-robin share of one boot ROM Wishbone
// slave port among N_MASTERS masters, one transfer in flight at a time.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wbm_*_i         packed per-master request buses (master i at slice i)
//   wbm_dat_o       slave read data broadcast to every master
//   wbm_ack/err_o   completion routed to the granted master only
//   wbm_rty_o       tied low
//   wbs_*_o/_i      single slave port, driven from the granted master
//   grant_o         one-hot current grant (debug)
//
// Optional: define BOOTROM_ARB_TIMEOUT_EN to abort a transfer with an
// error to the master when the slave stays silent for TIMEOUT cycles.

module bootrom_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS*32-1:0] wbm_adr_i,
  input  logic [N_MASTERS*32-1:0] wbm_dat_i,
  input  logic [N_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [N_MASTERS-1:0]    wbm_we_i,
  input  logic [N_MASTERS-1:0]    wbm_cyc_i,
  input  logic [N_MASTERS-1:0]    wbm_stb_i,
  output logic [31:0]             wbm_dat_o,
  output logic [N_MASTERS-1:0]    wbm_ack_o,
  output logic [N_MASTERS-1:0]    wbm_err_o,
  output logic [N_MASTERS-1:0]    wbm_rty_o,
  output logic [31:0]             wbs_adr_o,
  output logic [31:0]             wbs_dat_o,
  output logic [3:0]              wbs_sel_o,
  output logic                    wbs_we_o,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  input  logic [31:0]             wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic [N_MASTERS-1:0]    grant_o
);

  localparam int PW = $clog2(N_MASTERS);
  localparam logic [N_MASTERS-1:0] ONE = 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_MASTERS-1:0] grant_q;
  logic [PW-1:0]        gidx_q;
  logic [PW-1:0]        ptr_q;

  logic [N_MASTERS-1:0] req;
  logic [PW-1:0]        pick_idx;
  logic                 pick_found;
  logic [PW-1:0]        mux_idx;

  logic busy;
  logic g_cyc;
  logic g_req;
  logic slv_end;
  logic done;
  logic abort;
  logic tmo;
  logic arb_win;
  logic finish;

  assign req     = wbm_cyc_i & wbm_stb_i;
  assign busy    = (state_q == BUSY);
  assign g_cyc   = wbm_cyc_i[gidx_q];
  assign g_req   = g_cyc & wbm_stb_i[gidx_q];
  assign slv_end = wbs_ack_i | wbs_err_i;

  // A master dropping cyc wins over a same-cycle slave response:
  // it has left the bus, so nothing is returned to it.
  assign abort   = busy & ~g_cyc;
  assign done    = busy & g_cyc & slv_end;
  assign arb_win = ~busy & pick_found;
  assign finish  = done | tmo;

  // Round-robin search starting just after the last served master.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      j = (int'(ptr_q) + k) % N_MASTERS;
      if (!pick_found && req[j]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(j);
      end
    end
  end

`ifdef BOOTROM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Held at zero while idle, so it is clear on every BUSY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else if (!slv_end && cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A real ack or err in the limit cycle takes precedence.
  assign tmo = busy & g_cyc & ~slv_end
             & (cnt_q == CW'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // State register plus grant / pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      unique case (1'b1)
        arb_win: begin
          grant_q <= ONE << pick_idx;
          gidx_q  <= pick_idx;
        end
        finish: begin
          grant_q <= '0;
          ptr_q   <= gidx_q;
        end
        abort: begin
          grant_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pick_found) state_d = BUSY;
      BUSY: if (abort | finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mux_idx   = busy ? gidx_q : '0;
    wbs_adr_o = wbm_adr_i[int'(mux_idx)*32 +: 32];
    wbs_dat_o = wbm_dat_i[int'(mux_idx)*32 +: 32];
    wbs_sel_o = wbm_sel_i[int'(mux_idx)*4 +: 4];
    wbs_we_o  = wbm_we_i[mux_idx];
    wbs_cyc_o = busy & g_req & ~tmo;
    wbs_stb_o = busy & g_req & ~tmo;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (done) begin
      wbm_ack_o = grant_q & {N_MASTERS{wbs_ack_i}};
      wbm_err_o = grant_q & {N_MASTERS{wbs_err_i}};
    end else if (tmo) begin
      wbm_err_o = grant_q;
    end
  end

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_rty_o = '0;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: table vectors, directed corner sequences and a
// random run against a transfer-level round-robin model.

module tb_bootrom_arbiter;

  localparam int N = 4;
`ifdef BOOTROM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [N*32-1:0] wbm_adr_i;
  logic [N*32-1:0] wbm_dat_i;
  logic [N*4-1:0]  wbm_sel_i;
  logic [N-1:0]    wbm_we_i;
  logic [N-1:0]    wbm_cyc_i;
  logic [N-1:0]    wbm_stb_i;
  logic [31:0]     wbm_dat_o;
  logic [N-1:0]    wbm_ack_o;
  logic [N-1:0]    wbm_err_o;
  logic [N-1:0]    wbm_rty_o;
  logic [31:0]     wbs_adr_o;
  logic [31:0]     wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_we_o;
  logic            wbs_cyc_o;
  logic            wbs_stb_o;
  logic [31:0]     wbs_dat_i;
  logic            wbs_ack_i;
  logic            wbs_err_i;
  logic [N-1:0]    grant_o;

  logic [N-1:0] cyc;
  logic [N-1:0] stb;
  logic [N-1:0] we;
  logic [31:0]  adr [N];
  logic [31:0]  dat [N];
  logic [3:0]   sel [N];

  logic        auto_slv;
  logic        t_ack;
  logic        t_err;
  logic [31:0] t_dat;
  logic        s_ack_q = 1'b0;
  logic [31:0] s_dat_q = '0;

  int n_vec = 0;
  int n_bad = 0;

  bootrom_arbiter #(
    .N_MASTERS(N),
    .TIMEOUT  (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_we_i  (wbm_we_i),
    .wbm_cyc_i (wbm_cyc_i),
    .wbm_stb_i (wbm_stb_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .grant_o   (grant_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*32 +: 32] = adr[i];
      wbm_dat_i[i*32 +: 32] = dat[i];
      wbm_sel_i[i*4 +: 4]   = sel[i];
    end
  end

  assign wbm_we_i  = we;
  assign wbm_cyc_i = cyc;
  assign wbm_stb_i = stb;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h8) return 32'h1234_5678;
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  // ROM slave: registered ack one cycle after stb.
  always @(posedge clk) begin
    s_ack_q <= auto_slv & wbs_stb_o & ~s_ack_q;
    s_dat_q <= rom(wbs_adr_o);
  end

  assign wbs_ack_i = auto_slv ? s_ack_q : t_ack;
  assign wbs_err_i = auto_slv ? 1'b0 : t_err;
  assign wbs_dat_i = auto_slv ? s_dat_q : t_dat;

  typedef struct {
    logic       rst;
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic [3:0] g;
    logic [3:0] ao;
    logic [3:0] eo;
    logic       sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] c, input logic [3:0] s,
    input logic a, input logic e, input logic [3:0] g,
    input logic [3:0] ao, input logic [3:0] eo, input logic sc);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a; v.err = e;
    v.g = g; v.ao = ao; v.eo = eo; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc = '0;
    stb = '0;
    t_ack = 1'b0;
    t_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gi;
    int own;
    int last;
    int ph;
    logic [N-1:0] drop;

    rst = 1'b1;
    cyc = '0;
    stb = '0;
    we = '0;
    auto_slv = 1'b0;
    t_ack = 1'b0;
    t_err = 1'b0;
    t_dat = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++) begin
      adr[i] = 32'h100 * i + 32'h4;
      dat[i] = 32'hA000_0000 + i;
      sel[i] = 4'(i + 1);
    end

    // Rows: rst, cyc, stb, slave ack, slave err | grant, ack, err, wbs_cyc
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b1010, 4'b1010, 1, 0, 4'b0010, 4'b0010, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 4'b1000, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 1, 0, 4'b1000, 4'b1000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0011, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 1, 4'b0010, 4'b0000, 4'b0010, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0100, 4'b0100, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 4'b0100, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 4'b0100, 4'b0100, 4'b0000, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0));

    // Reset state
    do_reset();
    #1;
    chk("rst grant", grant_o, 0);
    chk("rst wbs_cyc", wbs_cyc_o, 0);
    chk("rst wbs_stb", wbs_stb_o, 0);
    chk("rst ack", wbm_ack_o, 0);
    chk("rst err", wbm_err_o, 0);
    chk("rst rty", wbm_rty_o, 0);

    // Contention, abort, err, reset mid-transfer
    foreach (tbl[k]) begin
      @(negedge clk);
      rst   = tbl[k].rst;
      cyc   = tbl[k].cyc;
      stb   = tbl[k].stb;
      t_ack = tbl[k].ack;
      t_err = tbl[k].err;
      #1;
      chk($sformatf("tbl%0d grant", k), grant_o, tbl[k].g);
      chk($sformatf("tbl%0d ack", k), wbm_ack_o, tbl[k].ao);
      chk($sformatf("tbl%0d err", k), wbm_err_o, tbl[k].eo);
      chk($sformatf("tbl%0d wbs_cyc", k), wbs_cyc_o, tbl[k].sc);
      chk($sformatf("tbl%0d wbs_stb", k), wbs_stb_o, tbl[k].sc);
      chk($sformatf("tbl%0d rty", k), wbm_rty_o, 0);
      chk($sformatf("tbl%0d dat_o", k), wbm_dat_o, t_dat);
      gi = 0;
      for (int i = 0; i < N; i++) if (tbl[k].g[i]) gi = i;
      chk($sformatf("tbl%0d adr mux", k), wbs_adr_o, adr[gi]);
      chk($sformatf("tbl%0d sel mux", k), wbs_sel_o, sel[gi]);
    end
    rst = 1'b0;
    t_ack = 1'b0;
    t_err = 1'b0;

    // Single read through the ROM slave
    do_reset();
    auto_slv = 1'b1;
    @(negedge clk);
    adr[2] = 32'h8;
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    #1;
    chk("rd arb stb", wbs_stb_o, 0);
    @(negedge clk);
    #1;
    chk("rd busy stb", wbs_stb_o, 1);
    chk("rd busy adr", wbs_adr_o, 32'h8);
    chk("rd busy grant", grant_o, 4'b0100);
    chk("rd busy ack", wbm_ack_o, 0);
    @(negedge clk);
    #1;
    chk("rd ack", wbm_ack_o, 4'b0100);
    chk("rd data", wbm_dat_o, 32'h1234_5678);
    @(negedge clk);
    cyc = '0;
    stb = '0;
    #1;
    chk("rd after ack", wbm_ack_o, 0);
    chk("rd after stb", wbs_stb_o, 0);

    // Fairness with all masters requesting
    do_reset();
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cyc = '1;
        stb = '1;
      end
      #1;
      if (c % 3 == 0) chk($sformatf("fair%0d idle", c), grant_o, 0);
      if (c % 3 == 1)
        chk($sformatf("fair%0d grant", c), grant_o, 4'b0001 << ((c / 3) % 4));
      if (c % 3 == 2)
        chk($sformatf("fair%0d ack", c), wbm_ack_o, 4'b0001 << ((c / 3) % 4));
    end
    cyc = '0;
    stb = '0;

`ifdef BOOTROM_ARB_TIMEOUT_EN
    // Silent slave: error after TMO waiting cycles, then next master
    do_reset();
    auto_slv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cyc = 4'b0110;
        stb = 4'b0110;
      end
      if (c == 6) begin
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
      end
      t_ack = (c == 8);
      #1;
      if (c >= 1 && c <= 4) begin
        chk($sformatf("tmo%0d wait err", c), wbm_err_o, 0);
        chk($sformatf("tmo%0d wait cyc", c), wbs_cyc_o, 1);
      end
      if (c == 5) begin
        chk("tmo err pulse", wbm_err_o, 4'b0010);
        chk("tmo cyc drop", wbs_cyc_o, 0);
      end
      if (c == 6) chk("tmo idle err", wbm_err_o, 0);
      if (c == 7) chk("tmo next grant", grant_o, 4'b0100);
      if (c == 8) chk("tmo next ack", wbm_ack_o, 4'b0100);
    end
    t_ack = 1'b0;
    cyc = '0;
    stb = '0;
`endif

    // Random traffic vs transfer-level round-robin model
    do_reset();
    auto_slv = 1'b1;
    ph = 0;
    own = 0;
    last = N - 1;
    drop = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin
          cyc[i] = 1'b0;
          stb[i] = 1'b0;
        end
        if (!cyc[i] && $urandom_range(0, 2) == 0) begin
          cyc[i] = 1'b1;
          stb[i] = 1'b1;
          adr[i] = $urandom;
          dat[i] = $urandom;
          sel[i] = 4'($urandom);
          we[i]  = 1'($urandom);
        end
      end
      drop = '0;
      #1;
      chk($sformatf("rnd%0d err", c), wbm_err_o, 0);
      case (ph)
        0: begin
          chk($sformatf("rnd%0d idle grant", c), grant_o, 0);
          chk($sformatf("rnd%0d idle stb", c), wbs_stb_o, 0);
          chk($sformatf("rnd%0d idle ack", c), wbm_ack_o, 0);
          if (cyc != '0) begin
            for (int k = N; k >= 1; k--)
              if (cyc[(last + k) % N]) own = (last + k) % N;
            ph = 1;
          end
        end
        1: begin
          chk($sformatf("rnd%0d grant", c), grant_o, 1 << own);
          chk($sformatf("rnd%0d stb", c), wbs_stb_o, 1);
          chk($sformatf("rnd%0d adr", c), wbs_adr_o, adr[own]);
          chk($sformatf("rnd%0d wdat", c), wbs_dat_o, dat[own]);
          chk($sformatf("rnd%0d sel", c), wbs_sel_o, sel[own]);
          chk($sformatf("rnd%0d we", c), wbs_we_o, we[own]);
          chk($sformatf("rnd%0d early ack", c), wbm_ack_o, 0);
          ph = 2;
        end
        default: begin
          chk($sformatf("rnd%0d ack", c), wbm_ack_o, 1 << own);
          chk($sformatf("rnd%0d rdat", c), wbm_dat_o, rom(adr[own]));
          last = own;
          drop[own] = 1'b1;
          ph = 0;
        end
      endcase
    end
    cyc = '0;
    stb = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bootrom_arbiter.md
Name: bootrom_arbiter

Overview:
- Shares one boot ROM Wishbone slave port among N_MASTERS Wishbone masters, e.g. the instruction ports of all cores in a compute tile at boot.
- Arbitration is registered round-robin. One transfer is in flight at a time.
- Sits between the per-core bus interfaces and the ROM slave, which returns a registered ack one cycle after stb.

Parameters:
- N_MASTERS, 4, number of requesting masters (>=2).
- TIMEOUT, 255, cycles the arbiter waits for slave ack/err before aborting. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wbm_adr_i  in  N_MASTERS*32  master addresses; master i uses bits [32i+31:32i]
- wbm_dat_i  in  N_MASTERS*32  master write data
- wbm_sel_i  in  N_MASTERS*4  master byte selects
- wbm_we_i  in  N_MASTERS  master write enables
- wbm_cyc_i  in  N_MASTERS  master cycle
- wbm_stb_i  in  N_MASTERS  master strobe
- wbm_dat_o  out  32  read data, broadcast to all masters
- wbm_ack_o  out  N_MASTERS  per-master ack
- wbm_err_o  out  N_MASTERS  per-master error
- wbm_rty_o  out  N_MASTERS  per-master retry, constant 0
- wbs_adr_o  out  32  slave address
- wbs_dat_o  out  32  slave write data
- wbs_sel_o  out  4  slave byte select
- wbs_we_o  out  1  slave write enable
- wbs_cyc_o  out  1  slave cycle
- wbs_stb_o  out  1  slave strobe
- wbs_dat_i  in  32  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave error
- grant_o  out  N_MASTERS  one-hot current grant, for debug

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, grant_o=0
  - last-grant pointer=N_MASTERS-1, so master 0 has first priority
  - wbs_cyc_o=0, wbs_stb_o=0
  - all wbm_ack_o/err_o/rty_o=0
- A request from master i is wbm_cyc_i[i] & wbm_stb_i[i].
- State IDLE:
  - If any request is pending, select the first requester searching from (pointer+1) mod N_MASTERS upward with wrap.
  - Register the one-hot grant and go to BUSY.
  - No request: stay in IDLE.
  - Arbitration costs exactly 1 cycle.
- State BUSY:
  - wbs_cyc_o/wbs_stb_o = granted master's cyc&stb.
  - wbs_adr_o/dat_o/sel_o/we_o are muxed combinationally from the granted master.
- Completion:
  - When wbs_ack_i or wbs_err_i is seen in BUSY, forward it combinationally to the granted master only: wbm_ack_o[g]=wbs_ack_i, wbm_err_o[g]=wbs_err_i.
  - In the same cycle: pointer<=g, grant cleared, go to IDLE.
  - Non-granted masters never see ack/err.
- Minimum back-to-back spacing is 3 cycles per transfer (IDLE, BUSY, ack cycle). The strobe drops in IDLE, so the slave's toggling ack cannot produce a spurious second ack.
- Abort: if the granted master drops cyc in BUSY before ack, go to IDLE next cycle with no ack/err generated and the pointer unchanged. A late slave ack arriving in IDLE is ignored.
- Data path:
  - wbm_dat_o = wbs_dat_i always. Masters qualify it with their own ack.
  - When grant_o=0, slave-side outputs other than cyc/stb are driven from master 0 (don't-care).
- Simultaneous events: a request arriving in the ack cycle is considered in the following IDLE cycle using the updated pointer.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,N_MASTERS-1,0.
- Reset mid-operation:
  - Next cycle is IDLE with outputs at reset values.
  - No ack is delivered for the interrupted transfer.
  - Pointer returns to N_MASTERS-1.

Optional Feature:
BOOTROM_ARB_TIMEOUT_EN
- Defined:
  - A counter (width clog2(TIMEOUT+1)) clears on entering BUSY and increments each BUSY cycle without ack/err.
  - When it reaches TIMEOUT: assert wbm_err_o[g] for exactly one cycle, deassert wbs_cyc_o/stb_o, set pointer<=g, go to IDLE.
  - Ack and timeout in the same cycle: ack wins, no err.
- Undefined: no counter is built, TIMEOUT is ignored, and the arbiter waits indefinitely in BUSY.

Test Plan:
- Single read: master 2 requests adr 0x8, slave returns 0x1234_5678 with a registered ack -> wbs_stb_o high 1 cycle after request; wbm_ack_o=4'b0100 with wbm_dat_o=0x12345678; no other acks.
- Contention: masters 1 and 3 request in the same cycle after reset -> master 1 served first, then master 3; wbm_ack_o sequence 0010 then 1000.
- Fairness: all 4 masters request continuously for 8 transfers -> grant_o sequence 0001,0010,0100,1000 repeated twice; each transfer is 3 cycles.
- Abort: master 0 granted, drops cyc in the first BUSY cycle -> IDLE next cycle, no wbm_ack_o/err_o pulse; pending master 1 is granted afterwards.
- Reset mid-transfer: rst asserted in BUSY for master 2 -> next cycle wbs_cyc_o=0, grant_o=0, no ack to master 2; after reset, master 0 wins over master 2 when both request.
- Timeout (macro defined, TIMEOUT=4): slave never acks -> after 4 BUSY cycles wbm_err_o[g] pulses for 1 cycle and the arbiter serves the next requester.
